// File: rtl/peak_frame_collector_if.sv
// Detector-result / readout-stream bundle for peak_frame_collector.
// The peak_thresh member exists only when PEAK_FRAME_THRESH_EN is defined.
interface peak_frame_collector_if #(
  parameter int BIN_W  = 5,
  parameter int VAL_W  = 32,
  parameter int ADDR_W = 10
);
  logic                    frame_start;
  logic [BIN_W-1:0]        RangBin_counts;
  logic                    peak_valid;
  logic [VAL_W-1:0]        Peak_Value;
  logic [ADDR_W-1:0]       Peak_Addr;
`ifdef PEAK_FRAME_THRESH_EN
  logic [VAL_W-1:0]        peak_thresh;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic [5+ADDR_W+VAL_W:0] out_data;
  logic                    frame_done;
  logic                    busy;
  logic                    overflow;

  modport master (
`ifdef PEAK_FRAME_THRESH_EN
    output peak_thresh,
`endif
    output frame_start, RangBin_counts, peak_valid, Peak_Value, Peak_Addr, out_ready,
    input  out_valid, out_data, frame_done, busy, overflow
  );

  modport slave (
`ifdef PEAK_FRAME_THRESH_EN
    input  peak_thresh,
`endif
    input  frame_start, RangBin_counts, peak_valid, Peak_Value, Peak_Addr, out_ready,
    output out_valid, out_data, frame_done, busy, overflow
  );
endinterface

// File: rtl/peak_frame_collector.sv
// Collects one {flag, addr, value} entry per range bin into a register buffer, then drains it
// over a valid/ready stream. Define PEAK_FRAME_THRESH_EN to enable the echo threshold input.
module peak_frame_collector #(
  parameter int BIN_W  = 5,
  parameter int VAL_W  = 32,
  parameter int ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  peak_frame_collector_if.slave  bus
);
  localparam int DEPTH  = 2 ** BIN_W;
  localparam int ENT_W  = 1 + ADDR_W + VAL_W;
  localparam int DATA_W = 6 + ADDR_W + VAL_W;
  localparam logic [BIN_W-1:0] ONE = BIN_W'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, READOUT} state_t;

  state_t              state_q, state_d;
  logic [BIN_W-1:0]    n_q, n_d;
  logic [BIN_W-1:0]    wr_idx_q, wr_idx_d;
  logic [BIN_W-1:0]    rd_idx_q, rd_idx_d;
  logic                pv_prev_q;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;
  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic                wr_en;
  logic [ENT_W-1:0]    wr_entry;
  logic                rise;

  // Entry layout in the buffer is {flag, addr, value}; the bin index is added on readout.
  function automatic logic [DATA_W-1:0] format_entry(input logic [ENT_W-1:0] e,
                                                     input logic [BIN_W-1:0] idx);
    return {e[ENT_W-1], 5'(idx), e[ENT_W-2:0]};
  endfunction

  assign rise = bus.peak_valid & ~pv_prev_q;

  always_comb begin
    wr_entry = {1'b0, bus.Peak_Addr, bus.Peak_Value};
`ifdef PEAK_FRAME_THRESH_EN
    if (bus.Peak_Value < bus.peak_thresh) begin
      wr_entry = {1'b1, {(ENT_W-1){1'b0}}};
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.frame_start && bus.RangBin_counts != '0) begin
          state_d  = COLLECT;
          n_d      = bus.RangBin_counts;
          wr_idx_d = '0;
        end
      end
      COLLECT: begin
        // A new shot wins over a capture in the same cycle; the partial frame is dropped.
        if (bus.frame_start) begin
          if (bus.RangBin_counts != '0) begin
            n_d      = bus.RangBin_counts;
            wr_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (rise) begin
          wr_en    = 1'b1;
          wr_idx_d = wr_idx_q + ONE;
          if (wr_idx_q == n_q - ONE) begin
            state_d  = READOUT;
            rd_idx_d = '0;
          end
        end
      end
      READOUT: begin
        if (bus.frame_start || rise) begin
          overflow_d = 1'b1;
        end
        // out_data_q always presents the entry at rd_idx_q while out_valid_q is high.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = format_entry(mem_q[rd_idx_q], rd_idx_q);
        end else if (bus.out_ready) begin
          if (rd_idx_q == n_q - ONE) begin
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            rd_idx_d   = rd_idx_q + ONE;
            out_data_d = format_entry(mem_q[rd_idx_q + ONE], rd_idx_q + ONE);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      pv_prev_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      pv_prev_q    <= bus.peak_valid;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx_q] <= wr_entry;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;
endmodule
